// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-I subset CPU.
// Holds the opcode and funct encodings, the ALU operation enum, the
// writeback and next-PC select enums, and a small immediate helper.
package cpu_pkg;

    localparam int XLEN = 32;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, LUI
    } alu_op_t;

    // Source of the value written back to the register file
    typedef enum logic [1:0] {
        WB_ALU, WB_MEM, WB_PC4
    } wb_src_t;

    // Source of the next PC
    typedef enum logic [1:0] {
        PC_PLUS4, PC_BRANCH, PC_JUMP, PC_JR
    } pc_src_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [XLEN-1:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/single_cycle_cpu_if.sv
// Debug view of the CPU: register file, PC and the instruction at PC.
// master : driven by the CPU side (regs_debug, pc_debug, instr_debug)
// slave  : observer side (bench / monitors)
interface single_cycle_cpu_if;
    import cpu_pkg::*;

    logic [XLEN-1:0] regs_debug [0:31];
    logic [XLEN-1:0] pc_debug;
    logic [XLEN-1:0] instr_debug;

    modport master (output regs_debug, output pc_debug, output instr_debug);
    modport slave  (input  regs_debug, input  pc_debug, input  instr_debug);
endinterface

// File: rtl/ram_1r1w.sv
// Word RAM with one combinational read port and one write port that
// shares the same address, written on the rising clock edge.
// Ports: clk, we (write enable), addr (word index), wdata, rdata.
// The storage array is named mem so that benches can preload it.
module ram_1r1w
    import cpu_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [XLEN-1:0]          wdata,
    output logic [XLEN-1:0]          rdata
);

    logic [XLEN-1:0] mem [0:DEPTH-1];

    // Synchronous word write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/single_cycle_cpu.sv
// Single-cycle 32-bit MIPS-I subset CPU. Every instruction is fetched,
// decoded, executed and retired in one clk cycle.
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset (PC and registers to 0)
//   regs_debug  live register file, index = register number
//   pc_debug    current PC
//   instr_debug instruction currently fetched at PC
// Only the low address bits select a RAM word, so MARS text addresses
// (0x00400000 base) alias onto word 0 of the instruction RAM.
module single_cycle_cpu
    import cpu_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] regs_debug [0:31],
    output logic [31:0] pc_debug,
    output logic [31:0] instr_debug
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0] pc_r;
    logic [31:0] rf_r [0:31];

    logic [31:0] instr_s;
    logic [5:0]  opcode_s;
    logic [5:0]  funct_s;
    logic [4:0]  rs_s;
    logic [4:0]  rt_s;
    logic [4:0]  rd_s;
    logic [4:0]  shamt_s;
    logic [15:0] imm_s;
    logic [25:0] target_s;

    logic [31:0] rs_val_s;
    logic [31:0] rt_val_s;
    logic [31:0] imm_ext_s;

    // Decoded control
    logic        reg_we_s;
    logic        mem_we_s;
    logic        alu_imm_s;
    logic        imm_zero_s;
    logic        beq_s;
    logic        bne_s;
    logic [4:0]  dst_s;
    alu_op_t     alu_op_s;
    wb_src_t     wb_src_s;
    pc_src_t     base_pc_src_s;
    pc_src_t     pc_src_s;

    logic [31:0] alu_b_s;
    logic [31:0] alu_y_s;
    logic [31:0] mem_rdata_s;
    logic [31:0] wb_data_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] br_target_s;
    logic [31:0] j_target_s;
    logic [31:0] pc_next_s;
    logic        dmem_we_s;

    // ---------------- Fetch ----------------
    ram_1r1w #(.DEPTH(MEM_DEPTH)) instr_ram (
        .clk   (clk),
        .we    (1'b0),
        .addr  (pc_r[AW+1:2]),
        .wdata (32'h0000_0000),
        .rdata (instr_s)
    );

    assign opcode_s = instr_s[31:26];
    assign rs_s     = instr_s[25:21];
    assign rt_s     = instr_s[20:16];
    assign rd_s     = instr_s[15:11];
    assign shamt_s  = instr_s[10:6];
    assign funct_s  = instr_s[5:0];
    assign imm_s    = instr_s[15:0];
    assign target_s = instr_s[25:0];

    // Register reads see the pre-write contents; $0 is never written
    assign rs_val_s = rf_r[rs_s];
    assign rt_val_s = rf_r[rt_s];

    // ---------------- Control ----------------
    // Main decoder: unknown opcodes and functs fall through as NOPs
    always_comb begin
        reg_we_s      = 1'b0;
        mem_we_s      = 1'b0;
        alu_imm_s     = 1'b0;
        imm_zero_s    = 1'b0;
        beq_s         = 1'b0;
        bne_s         = 1'b0;
        dst_s         = rd_s;
        alu_op_s      = ADD;
        wb_src_s      = WB_ALU;
        base_pc_src_s = PC_PLUS4;
        case (opcode_s)
            OP_RTYPE: begin
                case (funct_s)
                    FN_ADD, FN_ADDU: begin reg_we_s = 1'b1; alu_op_s = ADD;  end
                    FN_SUB, FN_SUBU: begin reg_we_s = 1'b1; alu_op_s = SUB;  end
                    FN_AND:          begin reg_we_s = 1'b1; alu_op_s = AND;  end
                    FN_OR:           begin reg_we_s = 1'b1; alu_op_s = OR;   end
                    FN_XOR:          begin reg_we_s = 1'b1; alu_op_s = XOR;  end
                    FN_NOR:          begin reg_we_s = 1'b1; alu_op_s = NOR;  end
                    FN_SLT:          begin reg_we_s = 1'b1; alu_op_s = SLT;  end
                    FN_SLTU:         begin reg_we_s = 1'b1; alu_op_s = SLTU; end
                    FN_SLL:          begin reg_we_s = 1'b1; alu_op_s = SLL;  end
                    FN_SRL:          begin reg_we_s = 1'b1; alu_op_s = SRL;  end
                    FN_JR:           base_pc_src_s = PC_JR;
                    default:         reg_we_s = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                reg_we_s = 1'b1; dst_s = rt_s; alu_imm_s = 1'b1; alu_op_s = ADD;
            end
            OP_SLTI: begin
                reg_we_s = 1'b1; dst_s = rt_s; alu_imm_s = 1'b1; alu_op_s = SLT;
            end
            OP_ANDI: begin
                reg_we_s = 1'b1; dst_s = rt_s; alu_imm_s = 1'b1; imm_zero_s = 1'b1;
                alu_op_s = AND;
            end
            OP_ORI: begin
                reg_we_s = 1'b1; dst_s = rt_s; alu_imm_s = 1'b1; imm_zero_s = 1'b1;
                alu_op_s = OR;
            end
            OP_XORI: begin
                reg_we_s = 1'b1; dst_s = rt_s; alu_imm_s = 1'b1; imm_zero_s = 1'b1;
                alu_op_s = XOR;
            end
            OP_LUI: begin
                reg_we_s = 1'b1; dst_s = rt_s; alu_op_s = LUI;
            end
            OP_LW: begin
                reg_we_s = 1'b1; dst_s = rt_s; alu_imm_s = 1'b1; alu_op_s = ADD;
                wb_src_s = WB_MEM;
            end
            OP_SW: begin
                mem_we_s = 1'b1; alu_imm_s = 1'b1; alu_op_s = ADD;
            end
            OP_BEQ: beq_s = 1'b1;
            OP_BNE: bne_s = 1'b1;
            OP_J:   base_pc_src_s = PC_JUMP;
            OP_JAL: begin
                base_pc_src_s = PC_JUMP; reg_we_s = 1'b1; dst_s = 5'd31;
                wb_src_s = WB_PC4;
            end
            default: reg_we_s = 1'b0;
        endcase
    end

    // Immediate extension: logical immediates are zero-extended
    always_comb begin
        if (imm_zero_s) begin
            imm_ext_s = zext16(imm_s);
        end else begin
            imm_ext_s = sext16(imm_s);
        end
    end

    assign alu_b_s = alu_imm_s ? imm_ext_s : rt_val_s;

    // ---------------- ALU ----------------
    // Shifts take rt and shamt; lui ignores both register operands
    always_comb begin
        alu_y_s = 32'h0000_0000;
        case (alu_op_s)
            ADD:     alu_y_s = rs_val_s + alu_b_s;
            SUB:     alu_y_s = rs_val_s - alu_b_s;
            AND:     alu_y_s = rs_val_s & alu_b_s;
            OR:      alu_y_s = rs_val_s | alu_b_s;
            XOR:     alu_y_s = rs_val_s ^ alu_b_s;
            NOR:     alu_y_s = ~(rs_val_s | alu_b_s);
            SLT:     alu_y_s = {31'h0, ($signed(rs_val_s) < $signed(alu_b_s))};
            SLTU:    alu_y_s = {31'h0, (rs_val_s < alu_b_s)};
            SLL:     alu_y_s = rt_val_s << shamt_s;
            SRL:     alu_y_s = rt_val_s >> shamt_s;
            LUI:     alu_y_s = {imm_s, 16'h0000};
            default: alu_y_s = 32'h0000_0000;
        endcase
    end

    // ---------------- Data memory ----------------
    // No store may land while the core is held in reset
    assign dmem_we_s = mem_we_s & ~reset;

    ram_1r1w #(.DEPTH(MEM_DEPTH)) data_ram (
        .clk   (clk),
        .we    (dmem_we_s),
        .addr  (alu_y_s[AW+1:2]),
        .wdata (rt_val_s),
        .rdata (mem_rdata_s)
    );

    // Writeback source select
    always_comb begin
        wb_data_s = alu_y_s;
        case (wb_src_s)
            WB_ALU:  wb_data_s = alu_y_s;
            WB_MEM:  wb_data_s = mem_rdata_s;
            WB_PC4:  wb_data_s = pc_plus4_s;
            default: wb_data_s = alu_y_s;
        endcase
    end

    // Register file write port; $0 stays zero because it is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= 32'h0000_0000;
            end
        end else if (reg_we_s && (dst_s != 5'd0)) begin
            rf_r[dst_s] <= wb_data_s;
        end
    end

    // ---------------- Next PC ----------------
    assign pc_plus4_s  = pc_r + 32'd4;
    assign br_target_s = pc_plus4_s + {imm_ext_s[29:0], 2'b00};
    assign j_target_s  = {pc_plus4_s[31:28], target_s, 2'b00};

    // Branch resolution overrides the decoder's default PC source
    always_comb begin
        pc_src_s = base_pc_src_s;
        if (beq_s && (rs_val_s == rt_val_s)) begin
            pc_src_s = PC_BRANCH;
        end else if (bne_s && (rs_val_s != rt_val_s)) begin
            pc_src_s = PC_BRANCH;
        end else begin
            pc_src_s = base_pc_src_s;
        end
    end

    // Next-PC mux
    always_comb begin
        pc_next_s = pc_plus4_s;
        case (pc_src_s)
            PC_PLUS4:  pc_next_s = pc_plus4_s;
            PC_BRANCH: pc_next_s = br_target_s;
            PC_JUMP:   pc_next_s = j_target_s;
            PC_JR:     pc_next_s = rs_val_s;
            default:   pc_next_s = pc_plus4_s;
        endcase
    end

    // PC register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= 32'h0000_0000;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // ---------------- Debug views ----------------
    assign regs_debug  = rf_r;
    assign pc_debug    = pc_r;
    assign instr_debug = instr_s;

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Self-checking bench for single_cycle_cpu: directed programs plus random
// straight-line programs, each compared against an instruction-level
// reference model that executes one instruction per clock.
module tb_single_cycle_cpu;

    logic clk = 1'b0;
    logic reset;

    single_cycle_cpu_if dbg();

    single_cycle_cpu #(.MEM_DEPTH(256)) dut (
        .clk         (clk),
        .reset       (reset),
        .regs_debug  (dbg.regs_debug),
        .pc_debug    (dbg.pc_debug),
        .instr_debug (dbg.instr_debug)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_imem [0:255];
    logic [31:0] m_dmem [0:255];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_pc;
    logic [31:0] prog [$];

    logic [5:0] rfuncs [0:11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                  6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02};
    logic [5:0] iops [0:6] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

    localparam logic [31:0] HALT = 32'h1000_FFFF;  // beq $0,$0,-1

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rs, input int rt,
                                          input int rd, input int sh);
        return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] addr);
        return {op, addr[27:2]};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0000_0000;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0000_0000;
    endtask

    // Executes one instruction straight from the ISA definition
    task automatic model_step();
        logic [31:0] ins, a, b, se, ze, ea, res, nxt;
        int wr;
        ins = m_imem[m_pc[9:2]];
        a   = m_regs[ins[25:21]];
        b   = m_regs[ins[20:16]];
        se  = {{16{ins[15]}}, ins[15:0]};
        ze  = {16'h0000, ins[15:0]};
        ea  = a + se;
        nxt = m_pc + 32'd4;
        res = 32'h0000_0000;
        wr  = 0;
        case (ins[31:26])
            6'h00: begin
                wr = int'(ins[15:11]);
                case (ins[5:0])
                    6'h20, 6'h21: res = a + b;
                    6'h22, 6'h23: res = a - b;
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                    6'h00: res = b << ins[10:6];
                    6'h02: res = b >> ins[10:6];
                    6'h08: begin wr = 0; nxt = a; end
                    default: wr = 0;
                endcase
            end
            6'h08, 6'h09: begin wr = int'(ins[20:16]); res = ea; end
            6'h0A: begin wr = int'(ins[20:16]); res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
            6'h0C: begin wr = int'(ins[20:16]); res = a & ze; end
            6'h0D: begin wr = int'(ins[20:16]); res = a | ze; end
            6'h0E: begin wr = int'(ins[20:16]); res = a ^ ze; end
            6'h0F: begin wr = int'(ins[20:16]); res = {ins[15:0], 16'h0000}; end
            6'h23: begin wr = int'(ins[20:16]); res = m_dmem[ea[9:2]]; end
            6'h2B: m_dmem[ea[9:2]] = b;
            6'h04: if (a == b) nxt = nxt + (se << 2);
            6'h05: if (a != b) nxt = nxt + (se << 2);
            6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
            6'h03: begin wr = 31; res = nxt; nxt = {nxt[31:28], ins[25:0], 2'b00}; end
            default: wr = 0;
        endcase
        if (wr != 0) m_regs[wr] = res;
        m_pc = nxt;
    endtask

    task automatic check_regs_zero(input string tag);
        check_eq({tag, "_pc"}, dbg.pc_debug, 32'h0000_0000);
        for (int i = 0; i < 32; i++)
            check_eq($sformatf("%s_r%0d", tag, i), dbg.regs_debug[i], 32'h0000_0000);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 32; i++)
            check_eq($sformatf("%s_r%0d", tag, i), dbg.regs_debug[i], m_regs[i]);
    endtask

    // Loads prog into both memories, holds reset for two edges, checks reset state
    task automatic start_program(input string tag);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            m_imem[i] = (i < prog.size()) ? prog[i] : 32'h0000_0000;
            dut.instr_ram.mem[i] = m_imem[i];
        end
        repeat (2) @(negedge clk);
        model_reset();
        reset = 1'b0;
        check_regs_zero({tag, "_rst"});
        check_eq({tag, "_rst_instr"}, dbg.instr_debug, m_imem[0]);
    endtask

    task automatic run(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_eq($sformatf("%s_pc_c%0d", tag, c), dbg.pc_debug, m_pc);
            check_eq($sformatf("%s_instr_c%0d", tag, c), dbg.instr_debug, m_imem[m_pc[9:2]]);
        end
    endtask

    task automatic build_alu_prog();
        prog = {};
        prog.push_back(enc_i(6'h08, 0, 8, 5));          // addi $t0,$0,5
        prog.push_back(enc_i(6'h08, 0, 9, -3));         // addi $t1,$0,-3
        prog.push_back(enc_r(6'h20, 8, 9, 10, 0));      // add  $t2
        prog.push_back(enc_r(6'h22, 8, 9, 11, 0));      // sub  $t3
        prog.push_back(enc_r(6'h24, 8, 9, 12, 0));      // and  $t4
        prog.push_back(enc_r(6'h25, 8, 9, 13, 0));      // or   $t5
        prog.push_back(enc_r(6'h2A, 9, 8, 14, 0));      // slt  $t6,$t1,$t0
        prog.push_back(enc_r(6'h2B, 9, 8, 15, 0));      // sltu $t7,$t1,$t0
        prog.push_back(enc_i(6'h0F, 0, 17, 16'h1234));  // lui  $s1,0x1234
        prog.push_back(enc_i(6'h0D, 0, 18, 16'hFFFF));  // ori  $s2,$0,0xFFFF
        prog.push_back(enc_i(6'h08, 0, 0, 7));          // addi $0,$0,7
        prog.push_back(enc_r(6'h27, 8, 9, 20, 0));      // nor  $s4
        prog.push_back(HALT);
    endtask

    task automatic check_alu_consts(input string tag);
        check_eq({tag, "_t2_add"},  dbg.regs_debug[10], 32'd2);
        check_eq({tag, "_t3_sub"},  dbg.regs_debug[11], 32'd8);
        check_eq({tag, "_t4_and"},  dbg.regs_debug[12], 32'd5);
        check_eq({tag, "_t5_or"},   dbg.regs_debug[13], 32'hFFFF_FFFD);
        check_eq({tag, "_t6_slt"},  dbg.regs_debug[14], 32'd1);
        check_eq({tag, "_t7_sltu"}, dbg.regs_debug[15], 32'd0);
        check_eq({tag, "_s1_lui"},  dbg.regs_debug[17], 32'h1234_0000);
        check_eq({tag, "_s2_ori"},  dbg.regs_debug[18], 32'h0000_FFFF);
        check_eq({tag, "_zero"},    dbg.regs_debug[0],  32'd0);
        check_eq({tag, "_s4_nor"},  dbg.regs_debug[20], 32'd2);
    endtask

    function automatic logic [31:0] rand_instr(input int idx, input int len);
        int sel, rs, rt, rd;
        sel = int'($urandom_range(0, 9));
        rs  = int'($urandom_range(0, 31));
        rt  = int'($urandom_range(0, 31));
        rd  = int'($urandom_range(0, 31));
        case (sel)
            0, 1, 2: return enc_r(rfuncs[$urandom_range(0, 11)], rs, rt, rd, int'($urandom_range(0, 31)));
            3, 4:    return enc_i(iops[$urandom_range(0, 6)], rs, rt, int'($urandom_range(0, 65535)));
            5:       return enc_i(6'h23, rs, rt, int'($urandom_range(0, 65535)));
            6:       return enc_i(6'h2B, rs, rt, int'($urandom_range(0, 65535)));
            7:       return enc_i(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, rs, rt,
                                  (idx + 4 < len) ? int'($urandom_range(0, 3)) : 0);
            8:       return {6'h3F, 26'($urandom())};
            default: return enc_r(6'h3F, rs, rt, rd, 0);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            m_dmem[i] = $urandom();
            dut.data_ram.mem[i] = m_dmem[i];
        end
        m_dmem[5] = 32'hCAFE_F00D;
        dut.data_ram.mem[5] = 32'hCAFE_F00D;

        // ALU program
        build_alu_prog();
        start_program("alu");
        run("alu", 12);
        check_all_regs("alu");
        check_alu_consts("alu");

        // Reset after five instructions, then rerun to completion
        start_program("mid");
        run("mid", 5);
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        check_regs_zero("mid_rst");
        run("mid", 12);
        check_all_regs("mid");
        check_alu_consts("mid");

        // Branch / jump program at MARS addresses
        prog = {};
        prog.push_back(enc_i(6'h08, 0, 16, 16'h2A));    // 00 addi $s0,$0,0x2A
        prog.push_back(enc_i(6'h08, 0, 8, 1));          // 04 addi $t0,$0,1
        prog.push_back(enc_i(6'h04, 8, 8, 1));          // 08 beq $t0,$t0,+1 (taken)
        prog.push_back(enc_i(6'h08, 0, 19, 16'h0BAD));  // 0C skipped
        prog.push_back(enc_i(6'h08, 0, 17, 16'h58));    // 10 addi $s1,$0,0x58
        prog.push_back(enc_i(6'h04, 8, 0, 1));          // 14 beq $t0,$0,+1 (not taken)
        prog.push_back(enc_i(6'h08, 0, 18, 16'h4D));    // 18 addi $s2,$0,0x4D
        prog.push_back(enc_j(6'h02, 32'h0040_0030));    // 1C j 0x00400030
        for (int k = 0; k < 4; k++)
            prog.push_back(enc_i(6'h08, 0, 19, 16'h0BAD)); // 20..2C skipped
        prog.push_back(enc_i(6'h08, 0, 9, 3));          // 30 addi $t1,$0,3
        prog.push_back(enc_r(6'h20, 16, 17, 10, 0));    // add  $t2,$s0,$s1
        prog.push_back(enc_r(6'h25, 16, 17, 11, 0));    // or   $t3
        prog.push_back(enc_r(6'h22, 17, 16, 12, 0));    // sub  $t4,$s1,$s0
        prog.push_back(enc_r(6'h00, 0, 16, 13, 2));     // sll  $t5,$s0,2
        prog.push_back(enc_r(6'h02, 0, 17, 14, 1));     // srl  $t6,$s1,1
        prog.push_back(enc_r(6'h26, 16, 18, 15, 0));    // xor  $t7
        prog.push_back(enc_r(6'h27, 0, 0, 24, 0));      // nor  $t8,$0,$0
        prog.push_back(enc_r(6'h2B, 16, 17, 25, 0));    // sltu $t9,$s0,$s1
        prog.push_back(HALT);                           // 54
        start_program("br");
        run("br", 30);
        check_all_regs("br");
        check_eq("br_s0", dbg.regs_debug[16], 32'h2A);
        check_eq("br_s1", dbg.regs_debug[17], 32'h58);
        check_eq("br_s2", dbg.regs_debug[18], 32'h4D);
        check_eq("br_s3", dbg.regs_debug[19], 32'h0);
        check_eq("br_halt_pc", dbg.pc_debug, 32'h0040_0054);

        // Memory program
        prog = {};
        prog.push_back(enc_i(6'h08, 0, 8, 16'h1234));   // addi $t0,$0,0x1234
        prog.push_back(enc_i(6'h2B, 0, 8, 8));          // sw   $t0,8($0)
        prog.push_back(enc_i(6'h23, 0, 9, 8));          // lw   $t1,8($0)
        prog.push_back(enc_i(6'h23, 0, 10, 20));        // lw   $t2,20($0) preloaded
        prog.push_back(enc_i(6'h08, 0, 11, -4));        // addi $t3,$0,-4
        prog.push_back(enc_i(6'h2B, 11, 8, 16'h0404));  // sw   $t0,0x404($t3) -> word 0
        prog.push_back(enc_i(6'h23, 0, 12, 0));         // lw   $t4,0($0)
        prog.push_back(enc_i(6'h0C, 9, 13, 16'hF0F0));  // andi $t5
        prog.push_back(enc_i(6'h0E, 11, 14, 16'h00FF)); // xori $t6
        prog.push_back(enc_i(6'h0A, 11, 15, -3));       // slti $t7,$t3,-3
        prog.push_back(HALT);
        start_program("mem");
        run("mem", 14);
        check_all_regs("mem");
        check_eq("mem_t1_lw",   dbg.regs_debug[9],  32'h0000_1234);
        check_eq("mem_t2_pre",  dbg.regs_debug[10], 32'hCAFE_F00D);
        check_eq("mem_t4_alias",dbg.regs_debug[12], 32'h0000_1234);
        check_eq("mem_t5_andi", dbg.regs_debug[13], 32'h0000_1030);
        check_eq("mem_t6_xori", dbg.regs_debug[14], 32'hFFFF_FF03);
        check_eq("mem_t7_slti", dbg.regs_debug[15], 32'd1);

        // bne loop, jal / jr
        prog = {};
        prog.push_back(enc_i(6'h08, 0, 8, 0));          // 00 addi $t0,$0,0
        prog.push_back(enc_i(6'h08, 0, 9, 4));          // 04 addi $t1,$0,4
        prog.push_back(enc_i(6'h08, 8, 8, 1));          // 08 addi $t0,$t0,1
        prog.push_back(enc_i(6'h05, 8, 9, -2));         // 0C bne $t0,$t1,-2
        prog.push_back(enc_j(6'h03, 32'h0040_001C));    // 10 jal sub
        prog.push_back(enc_i(6'h08, 0, 16, 16'h77));    // 14 addi $s0,$0,0x77
        prog.push_back(HALT);                           // 18
        prog.push_back(enc_i(6'h08, 0, 17, 16'h55));    // 1C sub: addi $s1,$0,0x55
        prog.push_back(enc_r(6'h08, 31, 0, 0, 0));      // 20 jr $ra
        start_program("call");
        run("call", 25);
        check_all_regs("call");
        check_eq("call_t0", dbg.regs_debug[8],  32'd4);
        check_eq("call_ra", dbg.regs_debug[31], 32'h0000_0014);
        check_eq("call_s0", dbg.regs_debug[16], 32'h77);
        check_eq("call_s1", dbg.regs_debug[17], 32'h55);
        check_eq("call_pc", dbg.pc_debug, 32'h0000_0018);

        // Random straight-line programs with forward branches and NOPs
        for (int p = 0; p < 4; p++) begin
            prog = {};
            for (int k = 0; k < 40; k++) prog.push_back(rand_instr(k, 40));
            for (int k = 0; k < 8; k++) prog.push_back(32'h0000_0000);
            prog.push_back(HALT);
            start_program($sformatf("rnd%0d", p));
            run($sformatf("rnd%0d", p), 60);
            check_all_regs($sformatf("rnd%0d", p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
